// File: rtl/lb_mailbox_tx.sv
// lb_mailbox_tx
// Device-side LB slave. The CPU writes words over the LB into an outbound
// FIFO, and a local consumer drains that FIFO through a valid/ready stream.
// The STATUS, CTRL and SCRATCH registers can be read back over the LB.
//
// Ports:
//   lb_clk          - the only clock
//   rst_n           - synchronous, active-low reset
//   bus_addr        - LB byte offset; [3:2] selects TXDATA/STATUS/CTRL/SCRATCH
//   bus_wdata       - LB write data, lane-aligned to the addressed bytes
//   bus_write_width - 00 byte, 01 half, 1x word
//   wsel            - one-cycle write strobe for this slave
//   rdata           - combinational read data for the current bus_addr
//   out_valid       - FIFO head valid (gated by CTRL.EN)
//   out_data        - FIFO head word (registered)
//   out_ready       - consumer accepts the head word
//   irq             - level interrupt; constant 0 unless enabled
//
// Optional feature: define LB_MAILBOX_TX_IRQ_EN to enable the registered
// threshold interrupt (EN && level <= THRESH), mirrored on STATUS[11].

module lb_mailbox_tx #(
    parameter int DEPTH        = 4,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    lb_clk,
    input  logic                    rst_n,
    input  logic [OFFSET_WIDTH-1:0] bus_addr,
    input  logic [31:0]             bus_wdata,
    input  logic [1:0]              bus_write_width,
    input  logic                    wsel,
    output logic [31:0]             rdata,
    output logic                    out_valid,
    output logic [31:0]             out_data,
    input  logic                    out_ready,
    output logic                    irq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      out_data_q, out_data_d;
    logic [31:0]      scratch_q, scratch_d;
    logic             en_q, en_d;
    logic [3:0]       thresh_q, thresh_d;
    logic             ovf_q, ovf_d;

    logic [1:0]       reg_sel;
    logic [3:0]       lane_en;
    logic [31:0]      bit_mask;
    logic [31:0]      masked_wdata;
    logic             wr_tx, wr_status, wr_ctrl, wr_scratch;
    logic             flush;
    logic [PTR_W-1:0] level;
    logic [4:0]       level5;
    logic             empty, full;
    logic             pop, push_ok;
    logic             irq_bit;

    assign reg_sel = bus_addr[3:2];

    // Byte lanes touched by this write, from width and the low address bits.
    always_comb begin
        lane_en = 4'b0000;
        unique case (bus_write_width)
            2'b00:   lane_en[bus_addr[1:0]] = 1'b1;
            2'b01:   lane_en = bus_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign bit_mask     = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
    assign masked_wdata = bus_wdata & bit_mask;

    assign wr_tx      = wsel && (reg_sel == 2'd0);
    assign wr_status  = wsel && (reg_sel == 2'd1);
    assign wr_ctrl    = wsel && (reg_sel == 2'd2);
    assign wr_scratch = wsel && (reg_sel == 2'd3);

    // Every CTRL field lives in byte lane 0, so only writes covering lane 0 matter.
    assign flush = wr_ctrl && lane_en[0] && bus_wdata[1];

    assign level  = wr_ptr_q - rd_ptr_q;
    assign level5 = 5'(level);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign out_valid = en_q && !empty;
    assign out_data  = out_data_q;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = wr_tx && (!full || pop);

    // Next-state logic for pointers, registers and the registered head word.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        en_d       = en_q;
        thresh_d   = thresh_q;
        scratch_d  = scratch_q;
        out_data_d = out_data_q;

        // Flush beats a simultaneous pop; it can never coincide with a push.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (wr_tx && full && !pop) begin
            ovf_d = 1'b1;
        end else if (wr_status && bus_wdata[10]) begin
            ovf_d = 1'b0;
        end

        if (wr_ctrl && lane_en[0]) begin
            en_d     = bus_wdata[0];
            thresh_d = bus_wdata[7:4];
        end

        if (wr_scratch) begin
            scratch_d = (scratch_q & ~bit_mask) | masked_wdata;
        end

        // The next head may be the word being written right now (push into an
        // empty FIFO, or push+pop at level 1); memory is not updated yet then.
        if (wr_ptr_d == rd_ptr_d) begin
            out_data_d = '0;
        end else if (push_ok && (rd_ptr_d[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0])) begin
            out_data_d = masked_wdata;
        end else begin
            out_data_d = mem_q[rd_ptr_d[IDX_W-1:0]];
        end
    end

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            en_q       <= 1'b0;
            thresh_q   <= '0;
            scratch_q  <= '0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            thresh_q   <= thresh_d;
            scratch_q  <= scratch_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge lb_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= masked_wdata;
        end
    end

`ifdef LB_MAILBOX_TX_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = en_q && (level5 <= {1'b0, thresh_q});

    always_ff @(posedge lb_clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    assign irq     = 1'b0;
    assign irq_bit = 1'b0;
`endif

    // Reads have no side effects; TXDATA shows the head word even while EN=0.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            2'd0:    rdata = empty ? 32'd0 : out_data_q;
            2'd1:    rdata = {20'd0, irq_bit, ovf_q, full, empty, 3'd0, level5};
            2'd2:    rdata = {24'd0, thresh_q, 3'd0, en_q};
            default: rdata = scratch_q;
        endcase
    end

endmodule

// File: tb/tb_lb_mailbox_tx.sv
// tb_lb_mailbox_tx
// Self-checking bench for lb_mailbox_tx (DEPTH=4, OFFSET_WIDTH=4).
// A table of single-cycle bus operations with hand-computed register and
// stream expectations, followed by hand-written multi-cycle sequences for
// the EN gating, mid-operation reset and interrupt behaviour.

module tb_lb_mailbox_tx;

    logic        lb_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_write_width;
    logic        wsel;
    logic        out_ready;
    logic [31:0] rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        irq;

    int err_count   = 0;
    int check_count = 0;

    lb_mailbox_tx #(.DEPTH(4), .OFFSET_WIDTH(4)) dut (
        .lb_clk          (lb_clk),
        .rst_n           (rst_n),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_write_width (bus_write_width),
        .wsel            (wsel),
        .rdata           (rdata),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .irq             (irq)
    );

    always #5 lb_clk = ~lb_clk;

    typedef struct {
        logic        wsel;
        logic [3:0]  addr;
        logic [1:0]  width;
        logic [31:0] wdata;
        logic        ready;
        logic [3:0]  raddr;
        logic [31:0] exp_rdata;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic w, input logic [3:0] a, input logic [1:0] wd,
                                   input logic [31:0] d, input logic r, input logic [3:0] ra,
                                   input logic [31:0] er, input logic ev, input logic cd,
                                   input logic [31:0] ed);
        vec_t v;
        v.wsel = w; v.addr = a; v.width = wd; v.wdata = d; v.ready = r;
        v.raddr = ra; v.exp_rdata = er; v.exp_valid = ev; v.chk_data = cd; v.exp_data = ed;
        vecs.push_back(v);
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Read one register and compare it together with the stream outputs.
    task automatic checkOutput(input string name, input logic [3:0] raddr, input logic [31:0] exp_rdata,
                               input logic exp_valid, input logic chk_data, input logic [31:0] exp_data);
        logic [31:0] act;
        bus_addr = raddr;
        #1;
        act = rdata;
`ifdef LB_MAILBOX_TX_IRQ_EN
        if (raddr[3:2] == 2'd1) act[11] = 1'b0;
`endif
        checkValue({name, ".rdata"}, act, exp_rdata);
        checkValue({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        if (chk_data) checkValue({name, ".out_data"}, out_data, exp_data);
    endtask

    // Drive one bus cycle; the write (if any) lands on the following rising edge.
    task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [1:0] wd,
                                 input logic [31:0] d, input logic r);
        @(negedge lb_clk);
        wsel = w; bus_addr = a; bus_write_width = wd; bus_wdata = d; out_ready = r;
        @(posedge lb_clk);
        #1;
        wsel = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, 2'b10, d, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; wsel = 1'b0; bus_addr = '0; bus_wdata = '0;
        bus_write_width = 2'b10; out_ready = 1'b0;

        //     wsel  addr   wd     wdata          rdy  raddr  exp_rdata      v  chk exp_data
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b0, 4'h0, 32'h0,         0, 1, 32'h0);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b0, 4'h4, 32'h100,       0, 1, 32'h0);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b0, 4'h8, 32'h0,         0, 0, 32'h0);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b0, 4'hC, 32'h0,         0, 0, 32'h0);
        addVec(1'b1, 4'h8, 2'b10, 32'h1,         1'b0, 4'h8, 32'h1,         0, 0, 32'h0);
        addVec(1'b1, 4'h0, 2'b10, 32'h11111111,  1'b0, 4'h4, 32'h001,       1, 1, 32'h11111111);
        addVec(1'b1, 4'h0, 2'b10, 32'h22222222,  1'b0, 4'h4, 32'h002,       1, 1, 32'h11111111);
        addVec(1'b1, 4'h0, 2'b10, 32'h33333333,  1'b0, 4'h4, 32'h003,       1, 1, 32'h11111111);
        addVec(1'b1, 4'h0, 2'b10, 32'h44444444,  1'b0, 4'h4, 32'h204,       1, 1, 32'h11111111);
        addVec(1'b1, 4'h0, 2'b10, 32'h99999999,  1'b0, 4'h4, 32'h604,       1, 1, 32'h11111111);
        addVec(1'b1, 4'h0, 2'b10, 32'h55555555,  1'b1, 4'h4, 32'h604,       1, 1, 32'h22222222);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b1, 4'h0, 32'h33333333,  1, 1, 32'h33333333);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b1, 4'h0, 32'h44444444,  1, 1, 32'h44444444);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b1, 4'h4, 32'h401,       1, 1, 32'h55555555);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b1, 4'h0, 32'h0,         0, 0, 32'h0);
        addVec(1'b1, 4'h4, 2'b10, 32'h400,       1'b0, 4'h4, 32'h100,       0, 0, 32'h0);
        addVec(1'b1, 4'h2, 2'b00, 32'hABABABAB,  1'b0, 4'h0, 32'h00AB0000,  1, 1, 32'h00AB0000);
        addVec(1'b1, 4'hE, 2'b01, 32'hCDEFCDEF,  1'b0, 4'hC, 32'hCDEF0000,  1, 1, 32'h00AB0000);
        addVec(1'b1, 4'hC, 2'b00, 32'h12121212,  1'b0, 4'hC, 32'hCDEF0012,  1, 1, 32'h00AB0000);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b1, 4'h4, 32'h100,       0, 0, 32'h0);
        addVec(1'b1, 4'h0, 2'b10, 32'h000000A1,  1'b0, 4'h4, 32'h001,       1, 1, 32'h000000A1);
        addVec(1'b1, 4'h0, 2'b10, 32'h000000A2,  1'b0, 4'h4, 32'h002,       1, 1, 32'h000000A1);
        addVec(1'b1, 4'h0, 2'b10, 32'h000000A3,  1'b0, 4'h4, 32'h003,       1, 1, 32'h000000A1);
        addVec(1'b1, 4'h8, 2'b10, 32'h3,         1'b0, 4'h8, 32'h1,         0, 0, 32'h0);
        addVec(1'b0, 4'h0, 2'b10, 32'h0,         1'b0, 4'h4, 32'h100,       0, 0, 32'h0);
        addVec(1'b1, 4'h8, 2'b10, 32'h51,        1'b0, 4'h8, 32'h51,        0, 0, 32'h0);
        addVec(1'b1, 4'h9, 2'b00, 32'hFFFFFFFF,  1'b0, 4'h8, 32'h51,        0, 0, 32'h0);
        addVec(1'b1, 4'h8, 2'b10, 32'h0,         1'b0, 4'h8, 32'h0,         0, 0, 32'h0);
        addVec(1'b1, 4'h0, 2'b10, 32'h000000B1,  1'b0, 4'h4, 32'h001,       0, 0, 32'h0);
        addVec(1'b1, 4'h0, 2'b10, 32'h000000B2,  1'b0, 4'h4, 32'h002,       0, 0, 32'h0);

        repeat (3) @(posedge lb_clk);
        @(negedge lb_clk);
        rst_n = 1'b1;
        checkValue("reset.irq", {31'd0, irq}, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wsel, vecs[i].addr, vecs[i].width, vecs[i].wdata, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_rdata,
                        vecs[i].exp_valid, vecs[i].chk_data, vecs[i].exp_data);
        end

        // EN=0 holds the two queued words even with the consumer ready.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 4'h4, 2'b10, 32'h0, 1'b1);
            checkValue($sformatf("en0_hold%0d.out_valid", c), {31'd0, out_valid}, 32'd0);
        end
        checkOutput("en0_level", 4'h4, 32'h002, 1'b0, 1'b0, 32'h0);

        // Enable with ready held: nothing pops on the enabling edge, then two pops.
        @(negedge lb_clk);
        wsel = 1'b1; bus_addr = 4'h8; bus_write_width = 2'b10; bus_wdata = 32'h1; out_ready = 1'b1;
        @(posedge lb_clk);
        #1;
        wsel = 1'b0;
        checkValue("en1_first.out_valid", {31'd0, out_valid}, 32'd1);
        checkValue("en1_first.out_data", out_data, 32'h000000B1);
        @(posedge lb_clk);
        #1;
        checkValue("en1_second.out_valid", {31'd0, out_valid}, 32'd1);
        checkValue("en1_second.out_data", out_data, 32'h000000B2);
        @(posedge lb_clk);
        #1;
        out_ready = 1'b0;
        checkOutput("en1_drained", 4'h4, 32'h100, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of operation discards queued words and registers.
        busWrite(4'h0, 32'h000000C1);
        busWrite(4'h0, 32'h000000C2);
        busWrite(4'hC, 32'h5A5A5A5A);
        checkOutput("pre_rst", 4'h4, 32'h002, 1'b1, 1'b1, 32'h000000C1);
        @(negedge lb_clk);
        rst_n = 1'b0;
        @(posedge lb_clk);
        #1;
        checkOutput("mid_rst_status", 4'h4, 32'h100, 1'b0, 1'b1, 32'h0);
        checkOutput("mid_rst_ctrl", 4'h8, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("mid_rst_scratch", 4'hC, 32'h0, 1'b0, 1'b0, 32'h0);
        checkValue("mid_rst.irq", {31'd0, irq}, 32'd0);
        @(negedge lb_clk);
        rst_n = 1'b1;

`ifdef LB_MAILBOX_TX_IRQ_EN
        busWrite(4'h8, 32'h11);
        busWrite(4'h0, 32'h000000D1);
        busWrite(4'h0, 32'h000000D2);
        busWrite(4'h0, 32'h000000D3);
        applyStimulus(1'b0, 4'h4, 2'b10, 32'h0, 1'b0);
        checkValue("irq_level3", {31'd0, irq}, 32'd0);
        applyStimulus(1'b0, 4'h4, 2'b10, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h4, 2'b10, 32'h0, 1'b1);
        checkValue("irq_level1_now", {31'd0, irq}, 32'd0);
        applyStimulus(1'b0, 4'h4, 2'b10, 32'h0, 1'b0);
        checkValue("irq_level1_next", {31'd0, irq}, 32'd1);
        bus_addr = 4'h4;
        #1;
        checkValue("irq_status11", {31'd0, rdata[11]}, 32'd1);
        busWrite(4'h0, 32'h000000D4);
        busWrite(4'h0, 32'h000000D5);
        busWrite(4'h0, 32'h000000D6);
        busWrite(4'h0, 32'h000000D7);
        bus_addr = 4'h4;
        #1;
        checkValue("irq_ovf_set", {31'd0, rdata[10]}, 32'd1);
        busWrite(4'h4, 32'h400);
        bus_addr = 4'h4;
        #1;
        checkValue("irq_ovf_clr", {31'd0, rdata[10]}, 32'd0);
`else
        busWrite(4'h8, 32'hF1);
        applyStimulus(1'b0, 4'h4, 2'b10, 32'h0, 1'b0);
        checkValue("no_irq_feature", {31'd0, irq}, 32'd0);
        checkOutput("no_irq_status", 4'h4, 32'h100, 1'b0, 1'b0, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/lb_mailbox_tx.md
Name: lb_mailbox_tx

Overview:
- Low-speed bus (LB) slave/responder: the device-side end of the LB bridge transfer.
- CPU writes words through the LB into an outbound FIFO; a local consumer drains the FIFO through a valid/ready stream.
- Status, control and scratch registers are readable over the LB.
- Sits on one `lb_wsel` / `lb_data_in` slot of the LB fabric, clocked by `lb_clk`.

Parameters:
- `DEPTH`, 4, FIFO entries; must be a power of 2, range 2..16.
- `OFFSET_WIDTH`, 4, LB offset bits seen by this slave (byte address; bits [3:2] select the register).

Ports:
- `lb_clk`  input  1  LB clock; the only clock.
- `rst_n`  input  1  reset; synchronous, active-low.
- `bus_addr`  input  `OFFSET_WIDTH`  LB offset (`bus.addr`).
- `bus_wdata`  input  32  LB write data (`bus.wdata`).
- `bus_write_width`  input  2  00 byte, 01 half, 10/11 word.
- `wsel`  input  1  write strobe for this slave (its `lb_wsel` slot); one `lb_clk` pulse per write.
- `rdata`  output  32  read data to the `lb_data_in` slot; combinational from `bus_addr` and registers.
- `out_valid`  output  1  FIFO head valid.
- `out_data`  output  32  FIFO head word.
- `out_ready`  input  1  consumer accepts head.
- `irq`  output  1  level interrupt (optional feature only; tied 0 otherwise).

Behaviour:
- Reset, synchronous, active-low, sampled on `lb_clk` rising edge:
  - FIFO empty; `out_valid`=0; `out_data`=0.
  - CTRL=0, SCRATCH=0, OVF=0, `irq`=0.
  - `rdata` reflects the reset registers.
  - Reset mid-operation discards all FIFO contents.
- Register map (word offsets via `bus_addr[3:2]`; `bus_addr` bits above bit 3 ignored):
  - 0x0 TXDATA:
    - Write pushes one entry.
    - Read returns the head word, or 0 when empty. Reads have no side effect: the LB carries no read strobe.
  - 0x4 STATUS, read-only except OVF:
    - [4:0] level (0..DEPTH).
    - [8] empty, [9] full, [10] OVF sticky.
    - Write with `bus_wdata[10]`=1 clears OVF.
  - 0x8 CTRL:
    - [0] EN: when 0, `out_valid` is forced 0 and no pop occurs.
    - [1] FLUSH: write 1 empties the FIFO; self-clears and reads back 0.
    - [7:4] THRESH.
  - 0xC SCRATCH: plain R/W.
- Write width and lane handling (applies to TXDATA, CTRL and SCRATCH):
  - Byte: lane `bus_addr[1:0]`.
  - Half: lanes {`bus_addr[1]`,0} and {`bus_addr[1]`,1}.
  - Word: all lanes.
  - Unwritten lanes: keep their value for CTRL/SCRATCH; are 0 in the pushed TXDATA word.
- Write timing: a write takes effect at the `lb_clk` edge where `wsel`=1; the register is visible on `rdata` in the next cycle.
- Push/pop:
  - Push: `wsel` and offset 0x0.
  - Pop: `out_valid && out_ready`.
  - Not full: push accepted.
  - Full, no pop: push dropped and OVF set.
  - Full with pop in the same cycle: push accepted, level unchanged.
  - Empty with push: entry appears on `out_valid`/`out_data` in the next cycle (no fall-through).
  - Push and pop in the same cycle when level=1: head advances to the new word.
- Flush and push in the same write: impossible, since they target different offsets.
- Flush with a pop in the same cycle: flush wins; the FIFO ends empty.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full when the MSBs differ and the LSBs are equal.
- `out_data` is registered from FIFO memory at the head pointer; stable while `out_valid` && !`out_ready`.

Optional Feature:
- Macro: `LB_MAILBOX_TX_IRQ_EN`.
- Defined:
  - `irq` is registered, updated each cycle as EN && (level <= THRESH).
  - STATUS[11] mirrors `irq`.
- Not defined:
  - `irq`=0 constant.
  - STATUS[11] reads 0.
  - No comparator logic.

Test Plan:
- Reset, then read offsets 0x0/0x4/0x8/0xC -> `rdata` 0, 0x100, 0, 0; `out_valid`=0.
- EN=1, `out_ready`=0, word-write 0x11111111..0x44444444 to TXDATA (DEPTH=4) -> STATUS=0x204, `out_data`=0x11111111; a 5th write sets STATUS[10] and level stays 4; pop one while writing 0x55555555 in the same cycle -> level 4, last entry 0x55555555.
- Byte write 0xAB at offset 0x2 of TXDATA, then half write 0xCDEF at offset 0xE -> pushed word 0x00AB0000; SCRATCH=0xCDEF0000.
- FIFO holding 3 entries, write CTRL=0x3 -> next cycle level 0, `out_valid`=0, CTRL reads 0x1.
- EN=0 with 2 entries and `out_ready`=1 -> no pops for 10 cycles; set EN=1 -> two consecutive pops, then `out_valid`=0.
- With `LB_MAILBOX_TX_IRQ_EN`, THRESH=1, EN=1: level 3 -> `irq`=0; drain to 1 -> `irq`=1 one cycle after level reaches 1; write STATUS with bit10=1 -> OVF cleared.
